// File: rtl/gera_seq_pkg.sv
// Shared definitions for the serial sequence generator and its analyser bench.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gera_seq_pkg;

  // Width of the state encoding, shared with the analyser testbench.
  localparam int STATE_W = 2;

  // Generator states; S_PAR is only entered when the parity option is built in.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/gera_seq_shreg.sv
// Parallel-load / shift-left register, MSB out.
// Latency: loaded value visible one edge after i_load; one bit per i_shift.
// Backpressure: none; load wins over shift.
module gera_seq_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;

  // Load a new word, or move every bit one place towards the MSB.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_dat;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[WIDTH-1];

endmodule

// File: rtl/gera_seq.sv
// Serial sequence generator: sends a captured pattern MSB first, reps times, GAP idle cycles apart.
// Latency: first bit on w one edge after start is accepted; done one cycle after the last bit.
// Backpressure: none; start is ignored while busy. Option macro: GERA_SEQ_PARITY_EN (adds a parity bit per copy).
module gera_seq
  import gera_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  parameter int GAP   = 2
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  output logic             w,
  output logic             w_vld,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  state_t           r_state, w_nxt_state;
  logic [WIDTH-1:0] r_pat, w_nxt_pat;
  logic [BIT_W-1:0] r_bit, w_nxt_bit;
  logic [REP_W-1:0] r_rep, w_nxt_rep;
  logic [GAP_W-1:0] r_gap, w_nxt_gap;
  logic             r_w, r_vld, r_busy, r_done;
  logic             w_nxt_w, w_nxt_vld, w_nxt_busy, w_nxt_done;
  logic             w_load, w_shift, w_end, w_new;
  logic [WIDTH-1:0] w_src;
  logic             w_sh_msb;

  // The shift register holds only the bits still to be sent; the bit on the
  // wire lives in r_w, so a load stores the source word already shifted once.
  gera_seq_shreg #(.WIDTH(WIDTH)) u_shreg (
    .ck      (ck),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_dat   ({w_src[WIDTH-2:0], 1'b0}),
    .o_msb   (w_sh_msb)
  );

  // State register plus all counters and registered outputs.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_bit   <= '0;
      r_rep   <= '0;
      r_gap   <= '0;
      r_w     <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pat   <= w_nxt_pat;
      r_bit   <= w_nxt_bit;
      r_rep   <= w_nxt_rep;
      r_gap   <= w_nxt_gap;
      r_w     <= w_nxt_w;
      r_vld   <= w_nxt_vld;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
    end
  end

  // Next state and next output values; copy-end and copy-start are shared
  // by several states, so they are raised as flags and resolved after the case.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pat   = r_pat;
    w_nxt_bit   = r_bit;
    w_nxt_rep   = r_rep;
    w_nxt_gap   = r_gap;
    w_nxt_w     = 1'b0;
    w_nxt_vld   = 1'b0;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_src       = r_pat;
    w_end       = 1'b0;
    w_new       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_busy = 1'b0;
        if (start) begin
          w_nxt_pat = pattern;
          w_nxt_rep = reps;
          w_load    = 1'b1;
          w_src     = pattern;
          if (reps == '0) begin
            w_nxt_done = 1'b1;
          end else begin
            w_nxt_state = S_SHIFT;
            w_nxt_busy  = 1'b1;
            w_nxt_bit   = BIT_W'(WIDTH - 1);
            w_nxt_w     = pattern[WIDTH-1];
            w_nxt_vld   = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (r_bit != '0) begin
          w_shift   = 1'b1;
          w_nxt_bit = r_bit - BIT_W'(1);
          w_nxt_w   = w_sh_msb;
          w_nxt_vld = 1'b1;
        end else begin
`ifdef GERA_SEQ_PARITY_EN
          w_nxt_state = S_PAR;
          w_nxt_w     = ^r_pat;
          w_nxt_vld   = 1'b1;
`else
          w_end = 1'b1;
`endif
        end
      end
`ifdef GERA_SEQ_PARITY_EN
      S_PAR: begin
        w_end = 1'b1;
      end
`endif
      S_GAP: begin
        if (r_gap == '0) begin
          w_new = 1'b1;
        end else begin
          w_nxt_gap = r_gap - GAP_W'(1);
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_busy  = 1'b0;
      end
    endcase

    // Last bit of a copy: gap, immediate next copy, or finish.
    if (w_end) begin
      if (r_rep > REP_W'(1)) begin
        if (GAP > 0) begin
          w_nxt_state = S_GAP;
          w_nxt_gap   = GAP_W'(GAP - 1);
        end else begin
          w_new = 1'b1;
        end
      end else begin
        w_nxt_state = S_IDLE;
        w_nxt_busy  = 1'b0;
        w_nxt_done  = 1'b1;
      end
    end

    // Start of a repeated copy: reload from the captured pattern.
    if (w_new) begin
      w_nxt_state = S_SHIFT;
      w_load      = 1'b1;
      w_src       = r_pat;
      w_nxt_rep   = r_rep - REP_W'(1);
      w_nxt_bit   = BIT_W'(WIDTH - 1);
      w_nxt_w     = r_pat[WIDTH-1];
      w_nxt_vld   = 1'b1;
    end
  end

  assign w     = r_w;
  assign w_vld = r_vld;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_gera_seq.sv
// Directed bench for gera_seq (WIDTH=8, REP_W=4, GAP=2); build with GERA_SEQ_PARITY_EN for the parity variant.
// Latency: n/a.
// Backpressure: n/a.
module tb_gera_seq;

  logic       ck;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] reps;
  logic       w, w_vld, busy, done;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef GERA_SEQ_PARITY_EN
  localparam int          P       = 1;
  localparam logic [63:0] A5_BITS = 64'h14A;
  localparam logic [63:0] C3_BITS = 64'({9'h078, 9'h078, 9'h078});
`else
  localparam int          P       = 0;
  localparam logic [63:0] A5_BITS = 64'hA5;
  localparam logic [63:0] C3_BITS = 64'h3C3C3C;
`endif

  gera_seq #(.WIDTH(8), .REP_W(4), .GAP(2)) dut (
    .ck      (ck),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
    .w       (w),
    .w_vld   (w_vld),
    .busy    (busy),
    .done    (done)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a job at the current falling edge and samples every falling edge
  // until done is seen; returns in the done cycle. disturb_at >= 1 pulses a
  // bogus start with pattern FF on that cycle.
  task automatic run_job(input logic [7:0] pat, input logic [3:0] n, input int disturb_at,
                         output logic [63:0] bits, output int nbusy, output int ngap,
                         output int ncyc);
    bits  = '0;
    nbusy = 0;
    ngap  = 0;
    ncyc  = 0;
    start = 1'b1;
    pattern = pat;
    reps  = n;
    for (int c = 1; c <= 200; c++) begin
      @(negedge ck);
      ncyc  = c;
      start = 1'b0;
      if (c == disturb_at) begin
        start   = 1'b1;
        pattern = 8'hFF;
        reps    = 4'hF;
      end
      if (busy) nbusy++;
      if (w_vld) bits = {bits[62:0], w};
      if (busy && !w_vld) ngap++;
      if (!w_vld && w) chk("w_idle_zero", 64'(w), 64'd0);
      if (done) begin
        chk("done_vld_low", 64'(w_vld), 64'd0);
        return;
      end
    end
    chk("job_timeout", 64'd0, 64'd1);
  endtask

  logic [63:0] bits;
  int          nb, ng, nc;

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    reps    = 4'h0;
    #1;
    chk("rst_w", 64'(w), 64'd0);
    chk("rst_vld", 64'(w_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);

    // Single copy of A5.
    run_job(8'hA5, 4'd1, -1, bits, nb, ng, nc);
    chk("a5_bits", bits, A5_BITS);
    chk("a5_busy_cycles", 64'(nb), 64'(8 + P));
    chk("a5_gap_cycles", 64'(ng), 64'd0);
    chk("a5_done_busy", 64'(busy), 64'd0);
    @(negedge ck);
    chk("a5_done_once", 64'(done), 64'd0);

    // Three copies of 3C with two idle cycles between them.
    run_job(8'h3C, 4'd3, -1, bits, nb, ng, nc);
    chk("3c_bits", bits, C3_BITS);
    chk("3c_busy_cycles", 64'(nb), 64'(3 * (8 + P) + 4));
    chk("3c_gap_cycles", 64'(ng), 64'd4);

    // Reset asserted in the done cycle clears done between edges.
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);

    // Start and pattern change while busy must not disturb the job.
    run_job(8'hA5, 4'd1, 3, bits, nb, ng, nc);
    chk("dist_bits", bits, A5_BITS);
    chk("dist_busy_cycles", 64'(nb), 64'(8 + P));
    // Back-to-back job started in the done cycle.
    start   = 1'b1;
    pattern = 8'hA5;
    reps    = 4'd1;
    @(negedge ck);
    start = 1'b0;
    chk("chain_busy", 64'(busy), 64'd1);
    chk("chain_vld", 64'(w_vld), 64'd1);
    chk("chain_bit1", 64'(w), 64'd1);
    @(negedge ck);
    chk("chain_bit2", 64'(w), 64'd0);
    @(negedge ck);
    chk("chain_bit3", 64'(w), 64'd1);

    // Reset after the third bit clears outputs immediately.
    #2 rst = 1'b0;
    #1;
    chk("rst_job_w", 64'(w), 64'd0);
    chk("rst_job_vld", 64'(w_vld), 64'd0);
    chk("rst_job_busy", 64'(busy), 64'd0);
    chk("rst_job_done", 64'(done), 64'd0);
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);

    // reps = 0: done one cycle later, nothing sent.
    run_job(8'hA5, 4'd0, -1, bits, nb, ng, nc);
    chk("rep0_latency", 64'(nc), 64'd1);
    chk("rep0_bits", bits, 64'd0);
    chk("rep0_busy", 64'(nb), 64'd0);

`ifdef GERA_SEQ_PARITY_EN
    @(negedge ck);
    run_job(8'h07, 4'd1, -1, bits, nb, ng, nc);
    chk("par07_bits", bits, 64'h00F);
    chk("par07_busy", 64'(nb), 64'd9);
`endif

    @(negedge ck);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
